// File: rtl/instr_decode_queue_pkg.sv
// Shared MIPS decode types for the IF->ID queue: opcode constants, class enum, field struct.
// Purely declarative; no logic, so no latency or backpressure behaviour of its own.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    CLS_R    = 2'd0,
    CLS_I    = 2'd1,
    CLS_J    = 2'd2,
    CLS_RSVD = 2'd3
  } instr_class_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
  } instr_fields_t;

  // Logical immediates are unsigned; everything else sign-extends.
  function automatic logic imm_is_zext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/instr_field_split.sv
// Combinational MIPS word splitter: fields, class and extended immediate; zero latency.
// No storage and no handshake, so it never applies backpressure.
module instr_field_split
  import decode_pkg::*;
#(
  parameter int IMM_OUT_W = 32
) (
  input  logic [31:0]          instr,
  output instr_fields_t        fields,
  output instr_class_t         cls,
  output logic [IMM_OUT_W-1:0] imm_ext
);

  always_comb begin
    fields.op    = instr[31:26];
    fields.rs    = instr[25:21];
    fields.rt    = instr[20:16];
    fields.rd    = instr[15:11];
    fields.shamt = instr[10:6];
    fields.funct = instr[5:0];
    fields.imm16 = instr[15:0];
  end

  always_comb begin
    cls = CLS_I;
    if (instr[31:26] == OP_RTYPE)
      cls = CLS_R;
    else if ((instr[31:26] == OP_J) || (instr[31:26] == OP_JAL))
      cls = CLS_J;
  end

  // Size casts extend according to signedness, so IMM_OUT_W=16 is a plain pass-through.
  always_comb begin
    if (imm_is_zext(instr[31:26]))
      imm_ext = IMM_OUT_W'(instr[15:0]);
    else
      imm_ext = IMM_OUT_W'($signed(instr[15:0]));
  end

endmodule

// File: rtl/instr_decode_queue.sv
// IF->ID instruction queue with pre-decoded head; push visible after one edge, no in->out path.
// in_ready is count < DEPTH only; flush empties on next edge. INSTR_DECODE_QUEUE_JTARGET_EN adds jump/branch targets.
module instr_decode_queue
  import decode_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PC_W      = 32,
  parameter int IMM_OUT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [5:0]               out_op,
  output logic [4:0]               out_rs,
  output logic [4:0]               out_rt,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_shamt,
  output logic [5:0]               out_funct,
  output logic [15:0]              out_imm16,
  output logic [IMM_OUT_W-1:0]     out_imm_ext,
  output logic [1:0]               out_class,
  output logic [PC_W-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]   out_count
`ifdef INSTR_DECODE_QUEUE_JTARGET_EN
  , output logic [PC_W-1:0]        out_jtarget
  , output logic [PC_W-1:0]        out_btarget
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W+31:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push, pop;

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_count = count;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is intentionally not reset; the empty-queue masking hides stale words.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_pc, in_instr};
  end

  logic [31:0]          head_instr;
  logic [PC_W-1:0]      head_pc;
  instr_fields_t        head_fields;
  instr_class_t         head_cls;
  logic [IMM_OUT_W-1:0] head_imm_ext;

  assign {head_pc, head_instr} = mem[rd_ptr];

  instr_field_split #(.IMM_OUT_W(IMM_OUT_W)) u_split (
    .instr   (head_instr),
    .fields  (head_fields),
    .cls     (head_cls),
    .imm_ext (head_imm_ext)
  );

  always_comb begin
    out_op      = '0;
    out_rs      = '0;
    out_rt      = '0;
    out_rd      = '0;
    out_shamt   = '0;
    out_funct   = '0;
    out_imm16   = '0;
    out_imm_ext = '0;
    out_class   = '0;
    out_pc      = '0;
    if (out_valid) begin
      out_op      = head_fields.op;
      out_rs      = head_fields.rs;
      out_rt      = head_fields.rt;
      out_rd      = head_fields.rd;
      out_shamt   = head_fields.shamt;
      out_funct   = head_fields.funct;
      out_imm16   = head_fields.imm16;
      out_imm_ext = head_imm_ext;
      out_class   = head_cls;
      out_pc      = head_pc;
    end
  end

`ifdef INSTR_DECODE_QUEUE_JTARGET_EN
  logic [PC_W-1:0] pc_plus4;
  assign pc_plus4 = head_pc + PC_W'(4);

  always_comb begin
    out_jtarget = '0;
    out_btarget = '0;
    if (out_valid) begin
      out_jtarget = {pc_plus4[PC_W-1:28], head_instr[25:0], 2'b00};
      out_btarget = pc_plus4 + (PC_W'($signed(head_instr[15:0])) << 2);
    end
  end
`endif

endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed bench for instr_decode_queue at DEPTH=4: decode, full/empty, wrap, flush, async reset.
// Inputs change 1ns after the rising edge; outputs are checked before the next rising edge.
module tb_instr_decode_queue;

  logic        clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_imm_ext, out_pc;
  logic [5:0]  out_op, out_funct;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [15:0] out_imm16;
  logic [1:0]  out_class;
  logic [2:0]  out_count;
`ifdef INSTR_DECODE_QUEUE_JTARGET_EN
  logic [31:0] out_jtarget, out_btarget;
`endif

  int checks = 0;
  int errors = 0;

  instr_decode_queue #(.DEPTH(4), .PC_W(32), .IMM_OUT_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shamt(out_shamt), .out_funct(out_funct), .out_imm16(out_imm16),
    .out_imm_ext(out_imm_ext), .out_class(out_class), .out_pc(out_pc),
    .out_count(out_count)
`ifdef INSTR_DECODE_QUEUE_JTARGET_EN
    , .out_jtarget(out_jtarget), .out_btarget(out_btarget)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    step(); step();
    reset = 1'b0;
    step();

    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_count",     out_count, 0);
    chk("rst_pc",        out_pc,    0);
    chk("rst_op",        out_op,    0);
    chk("rst_imm_ext",   out_imm_ext, 0);
    chk("rst_class",     out_class, 0);

    // ADDI: nothing visible before the edge, decoded head after it
    in_valid = 1'b1; in_instr = 32'h2128FFFC; in_pc = 32'h100;
    #1;
    chk("no_comb_path", out_valid, 0);
    step();
    in_valid = 1'b0;
    chk("addi_valid", out_valid, 1);
    chk("addi_op",    out_op,    6'h08);
    chk("addi_rs",    out_rs,    9);
    chk("addi_rt",    out_rt,    8);
    chk("addi_imm",   out_imm_ext, 32'hFFFFFFFC);
    chk("addi_class", out_class, 1);
    chk("addi_pc",    out_pc,    32'h100);
    chk("addi_count", out_count, 1);

    push(32'h3508FFFF, 32'h104);
    push(32'h012A4020, 32'h108);
    chk("count3", out_count, 3);
    pop();
    chk("ori_pc",    out_pc,      32'h104);
    chk("ori_imm",   out_imm_ext, 32'h0000FFFF);
    chk("ori_class", out_class,   1);
    pop();
    chk("r_pc",    out_pc,    32'h108);
    chk("r_rs",    out_rs,    9);
    chk("r_rt",    out_rt,    10);
    chk("r_rd",    out_rd,    8);
    chk("r_shamt", out_shamt, 0);
    chk("r_funct", out_funct, 6'h20);
    chk("r_class", out_class, 0);
    chk("r_imm",   out_imm_ext, 32'h00004020);
    chk("r_count", out_count, 1);

    // Fill to DEPTH, then hold a fifth push
    push(32'h8D090000, 32'h10C);
    push(32'h8D090004, 32'h110);
    push(32'h8D090008, 32'h114);
    chk("full_count", out_count, 4);
    chk("full_ready", in_ready,  0);
    in_valid = 1'b1; in_instr = 32'hAD090000; in_pc = 32'h118;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("held_count", out_count, 4);
      chk("held_ready", in_ready,  0);
    end
    // Pop from a full queue while in_valid is high: push must still be refused
    out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("fullpop_count", out_count, 3);
    chk("fullpop_pc",    out_pc,    32'h10C);
    pop();
    chk("order_pc1", out_pc, 32'h110);
    pop();
    chk("order_pc2", out_pc, 32'h114);
    pop();
    chk("drained_valid", out_valid, 0);
    chk("drained_count", out_count, 0);
    chk("drained_pc",    out_pc,    0);

    // Continuous push/pop at count=2 across several pointer wraps
    push(32'h20010000, 32'h1000);
    push(32'h20010001, 32'h1004);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_instr = 32'h20010002 + i;
      in_pc    = 32'h1008 + 4 * i;
      #1;
      chk("wrap_pc",    out_pc,    32'h1000 + 4 * i);
      chk("wrap_count", out_count, 2);
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("wrap_tail_pc", out_pc, 32'h1028);
    step(); step();
    out_ready = 1'b0;
    chk("wrap_empty", out_count, 0);

    // Flush with count=3 while pushing and popping
    push(32'h24020001, 32'h2000);
    push(32'h24020002, 32'h2004);
    push(32'h24020003, 32'h2008);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_instr = 32'h24020004; in_pc = 32'h200C;
    #1;
    chk("flush_in_ready", in_ready, 1);
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_count", out_count, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_pc",    out_pc,    0);
    push(32'h24020005, 32'h3000);
    chk("postflush_pc",    out_pc,    32'h3000);
    chk("postflush_count", out_count, 1);

    // Async reset between edges drops the queue immediately
    push(32'h24020006, 32'h3004);
    chk("prereset_count", out_count, 2);
    #2 reset = 1'b1;
    #1;
    chk("areset_valid", out_valid, 0);
    chk("areset_count", out_count, 0);
    chk("areset_ready", in_ready,  1);
    chk("areset_pc",    out_pc,    0);
    #1 reset = 1'b0;
    step();

`ifdef INSTR_DECODE_QUEUE_JTARGET_EN
    push(32'h08000040, 32'h00400000);
    push(32'h1000FFFF, 32'h200);
    chk("j_class",   out_class,   2);
    chk("jtarget",   out_jtarget, 32'h00000100);
    pop();
    chk("btarget",   out_btarget, 32'h200);
    pop();
    chk("jt_empty",  out_jtarget, 0);
    chk("bt_empty",  out_btarget, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
